pads_sound_tone_seq: RTL and testbench

//  Tone sequencer directly downstream of the PADS_SOUND AXI4-Lite register slave.
//  - Register slave emits one command per write to the command register.
//  - Commands queue in a small FIFO and play back one at a time.
//  - Each command plays a square wave of programmed half-period for a programmed number of ms.
//  - Output drives the board audio amplifier pin (audio_out, plus shutdown-control audio_en).

---
 rtl/pads_sound_pkg.sv | 28 ++
 rtl/pads_sound_cmd_fifo.sv | 66 ++++++
 rtl/pads_sound_tone_seq.sv | 160 ++++++++++++++++
 tb/tb_pads_sound_tone_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pads_sound_pkg.sv
// Shared types and helpers for the PADS_SOUND tone sequencer.
// Command layout, sequencer states and millisecond tick arithmetic.
package pads_sound_pkg;

    localparam int TONE_PERIOD_W = 16;
    localparam int TONE_DUR_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } tone_state_t;

    typedef struct packed {
        logic [TONE_PERIOD_W-1:0] half_per;
        logic [TONE_DUR_W-1:0]    dur_ms;
    } tone_cmd_t;

    function automatic int ms_ticks(input int clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pads_sound_cmd_fifo.sv
// Synchronous show-ahead FIFO of tone commands with flush.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module pads_sound_cmd_fifo
    import pads_sound_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  tone_cmd_t              din,
    output tone_cmd_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    tone_cmd_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_en;
    logic            rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop & ~empty & ~flush;
    assign wr_en = push & ~flush & (~full | rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pads_sound_tone_seq.sv
// Tone sequencer: queues commands from the register slave and plays each as a
// square wave of programmed half-period for a programmed number of milliseconds.
module pads_sound_tone_seq
    import pads_sound_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int FIFO_DEPTH  = 4,
    parameter int PERIOD_W    = TONE_PERIOD_W,
    parameter int DUR_W       = TONE_DUR_W
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        cmd_push,
    input  logic [PERIOD_W-1:0]         cmd_half_per,
    input  logic [DUR_W-1:0]            cmd_dur_ms,
    input  logic                        stop,
    input  logic                        ovf_clr,
    output logic                        audio_out,
    output logic                        audio_en,
    output logic                        busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int               TICKS    = ms_ticks(CLK_FREQ_HZ);
    localparam int               PRE_W    = cnt_width(TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS - 1);

    tone_state_t          state;
    tone_state_t          state_nxt;
    tone_cmd_t            cmd_in;
    tone_cmd_t            head;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 ovf_set;
    logic [PERIOD_W-1:0]  half_per;
    logic [PERIOD_W-1:0]  phase;
    logic [DUR_W-1:0]     rem_ms;
    logic [PRE_W-1:0]     pre;
    logic                 ms_wrap;
    logic                 tone_done;

    assign cmd_in    = '{half_per: cmd_half_per, dur_ms: cmd_dur_ms};
    // A push coinciding with stop is discarded outright, so it can never count as overflow.
    assign fifo_push = cmd_push & ~stop;
    assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;
    assign ms_wrap   = (pre == PRE_LAST);
    assign tone_done = ms_wrap && (rem_ms <= DUR_W'(1));
    assign busy      = (state != IDLE) || !fifo_empty;

    pads_sound_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (stop),
        .din   (cmd_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD:    state_nxt = (rem_ms == '0) ? IDLE : PLAY;
            PLAY:    if (tone_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = IDLE;
            fifo_pop  = 1'b0;
        end
    end

    // The head is captured on the popping edge, so LOAD only has to decide and clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            half_per  <= '0;
            rem_ms    <= '0;
            phase     <= '0;
            pre       <= '0;
            audio_out <= 1'b0;
            audio_en  <= 1'b0;
        end else begin
            if (fifo_pop) begin
                half_per <= head.half_per;
                rem_ms   <= head.dur_ms;
            end
            case (state)
                LOAD: begin
                    phase     <= '0;
                    pre       <= '0;
                    audio_out <= 1'b0;
                    audio_en  <= (rem_ms != '0);
                end
                PLAY: begin
                    pre <= ms_wrap ? '0 : pre + 1'b1;
                    if (ms_wrap) begin
                        rem_ms <= rem_ms - 1'b1;
                    end
                    // Half-periods of 0 or 1 are rests: the pin stays low.
                    if (half_per <= PERIOD_W'(1)) begin
                        phase     <= '0;
                        audio_out <= 1'b0;
                    end else if (phase == half_per - 1'b1) begin
                        phase     <= '0;
                        audio_out <= ~audio_out;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                    if (tone_done) begin
                        audio_out <= 1'b0;
                        audio_en  <= 1'b0;
                    end
                end
                default: begin
                    audio_out <= 1'b0;
                    audio_en  <= 1'b0;
                end
            endcase
            if (stop) begin
                audio_out <= 1'b0;
                audio_en  <= 1'b0;
            end
        end
    end

    // Set wins over clear; stop leaves the flag alone.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pads_sound_tone_seq.sv
// Bench for pads_sound_tone_seq: directed scenarios plus random traffic against
// a timeline model (tone start/end cycles, queue contents) at 10 cycles per ms.
module tb_pads_sound_tone_seq;

    localparam int TICKS = 10;
    localparam int DEPTH = 4;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cmd_push = 1'b0;
    logic [15:0] cmd_half_per = '0;
    logic [15:0] cmd_dur_ms = '0;
    logic        stop = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        audio_out;
    logic        audio_en;
    logic        busy;
    logic        fifo_full;
    logic [2:0]  fifo_level;
    logic        overflow;

    int total = 0;
    int bad = 0;

    typedef struct {
        int hp;
        int dur;
    } mcmd_t;

    // Model: queued commands, edge count, cycle at which the sequencer is idle again,
    // and the current tone's play window [ps, pe) with its half-period.
    mcmd_t q[$];
    int    cyc = 0;
    int    ready = 0;
    int    ps = 0;
    int    pe = 0;
    int    php = 0;
    bit    movf = 1'b0;

    pads_sound_tone_seq #(
        .CLK_FREQ_HZ (10_000),
        .FIFO_DEPTH  (4),
        .PERIOD_W    (16),
        .DUR_W       (16)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cmd_push     (cmd_push),
        .cmd_half_per (cmd_half_per),
        .cmd_dur_ms   (cmd_dur_ms),
        .stop         (stop),
        .ovf_clr      (ovf_clr),
        .audio_out    (audio_out),
        .audio_en     (audio_en),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_busy();
        return (cyc < ready) || (q.size() > 0);
    endfunction

    task automatic check_all();
        bit en;
        bit ao;
        en = (cyc >= ps) && (cyc < pe);
        ao = 1'b0;
        if (en && php >= 2) begin
            ao = (((cyc - ps) / php) % 2) == 1;
        end
        check("audio_en",   32'(audio_en),   32'(en));
        check("audio_out",  32'(audio_out),  32'(ao));
        check("busy",       32'(busy),       32'(model_busy()));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("fifo_full",  32'(fifo_full),  32'(q.size() == DEPTH));
        check("overflow",   32'(overflow),   32'(movf));
    endtask

    task automatic check_reset_outputs();
        check("rst_audio_out",  32'(audio_out),  32'd0);
        check("rst_audio_en",   32'(audio_en),   32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_fifo_full",  32'(fifo_full),  32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
    endtask

    // One clock: drive inputs, advance the model across the edge, check at the falling edge.
    task automatic step(input bit p, input int hp, input int dur, input bit s, input bit c);
        bit    popped;
        bit    ovf_evt;
        mcmd_t m;
        cmd_push     = p;
        cmd_half_per = 16'(hp);
        cmd_dur_ms   = 16'(dur);
        stop         = s;
        ovf_clr      = c;
        @(posedge ACLK);
        cyc++;
        popped  = !s && (q.size() > 0) && (cyc - 1 >= ready);
        ovf_evt = 1'b0;
        if (s) begin
            q.delete();
            ready = cyc;
            if (pe > cyc) pe = cyc;
        end
        if (popped) begin
            m     = q.pop_front();
            ps    = cyc + 1;
            pe    = cyc + 1 + m.dur * TICKS;
            php   = m.hp;
            ready = (m.dur == 0) ? cyc + 1 : pe;
        end
        if (p && !s) begin
            if (q.size() < DEPTH) begin
                m.hp  = hp;
                m.dur = dur;
                q.push_back(m);
            end else begin
                ovf_evt = 1'b1;
            end
        end
        if (ovf_evt) movf = 1'b1;
        else if (c) movf = 1'b0;
        @(negedge ACLK);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 0, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic push(input int hp, input int dur);
        step(1'b1, hp, dur, 1'b0, 1'b0);
    endtask

    task automatic mid_reset();
        #2 ARESETN = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge ACLK);
        @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        q.delete();
        ready = cyc;
        ps    = 0;
        pe    = 0;
        php   = 0;
        movf  = 1'b0;
        check_all();
    endtask

    initial begin
        // Power-on reset
        @(posedge ACLK);
        @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs();
        ARESETN = 1'b1;
        idle(3);

        // Single tone: half-period 3, 2 ms
        push(3, 2);
        idle(25);

        // Back-to-back tone, rest, tone
        push(5, 1);
        push(0, 2);
        push(2, 1);
        idle(50);

        // Overfill while playing, clear with concurrent overflow, then plain clear
        push(3, 3);
        for (int i = 0; i < 6; i++) push(2, 1);
        step(1'b1, 2, 1, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(3);

        // Stop mid-tone with a push in the same cycle
        step(1'b1, 4, 1, 1'b1, 1'b0);
        idle(3);

        // Zero-duration command is discarded
        push(4, 0);
        idle(5);

        // Keep pushing while full so one push lands on the popping edge
        push(2, 1);
        for (int i = 0; i < 16; i++) push(0, 1);
        idle(80);

        // Asynchronous reset during a tone
        push(6, 3);
        idle(12);
        mid_reset();
        idle(5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                 $urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0);
        end

        for (int i = 0; i < 400 && model_busy(); i++) idle(1);
        idle(2);
        check("drained_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
